// File: rtl/writeback_rf_pkg.sv
// writeback_rf_pkg
//   Shared definitions for the writeback register file slice:
//   - wb_sel_e   : W_Control write-data select encodings
//   - PSR_*      : condition-code values {N,Z,P}
//   - WB_COUNT_W : width of the committed-write counter
package writeback_rf_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU     = 2'd0,
        WB_SEL_PC      = 2'd1,
        WB_SEL_MEM     = 2'd2,
        WB_SEL_ILLEGAL = 2'd3
    } wb_sel_e;

    localparam logic [2:0] PSR_N     = 3'b100;
    localparam logic [2:0] PSR_Z     = 3'b010;
    localparam logic [2:0] PSR_P     = 3'b001;
    localparam logic [2:0] PSR_RESET = 3'b000;

    localparam int unsigned WB_COUNT_W = 16;

endpackage

// File: rtl/writeback_rf_if.sv
// writeback_rf_if
//   Bus bundle between a writeback stage (master) and the register file (slave).
//   Master drives: enable_writeback, W_Control, aluout, pcout, memout, dr, sr
//   Slave drives : VSR (packed registered read data), psr, wb_err, wb_count
//   Parameters DATA_W / NUM_REGS / NUM_RD must match the attached writeback_rf.
interface writeback_rf_if
    import writeback_rf_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned NUM_RD   = 2
);
    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic                       enable_writeback;
    logic [1:0]                 W_Control;
    logic [DATA_W-1:0]          aluout;
    logic [DATA_W-1:0]          pcout;
    logic [DATA_W-1:0]          memout;
    logic [ADDR_W-1:0]          dr;
    logic [NUM_RD*ADDR_W-1:0]   sr;
    logic [NUM_RD*DATA_W-1:0]   VSR;
    logic [2:0]                 psr;
    logic                       wb_err;
    logic [WB_COUNT_W-1:0]      wb_count;

    modport master (
        output enable_writeback, W_Control, aluout, pcout, memout, dr, sr,
        input  VSR, psr, wb_err, wb_count
    );

    modport slave (
        input  enable_writeback, W_Control, aluout, pcout, memout, dr, sr,
        output VSR, psr, wb_err, wb_count
    );

endinterface

// File: rtl/writeback_rf_nzp.sv
// writeback_rf_nzp
//   Combinational condition-code derivation from a data word.
//   data : DATA_W input word
//   psr  : {N,Z,P} one-hot; N when MSB set, Z when all zero, P otherwise
module writeback_rf_nzp
    import writeback_rf_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] data,
    output logic [2:0]        psr
);

    always_comb begin
        if (data[DATA_W-1]) begin
            psr = PSR_N;
        end else if (data == '0) begin
            psr = PSR_Z;
        end else begin
            psr = PSR_P;
        end
    end

endmodule

// File: rtl/writeback_rf.sv
// writeback_rf
//   Writeback-stage register file with NUM_RD registered read ports.
//   clock : rising-edge clock
//   reset : synchronous active-high reset (clears rf, VSR, psr, wb_err, wb_count)
//   bus   : writeback_rf_if.slave
//             enable_writeback/W_Control select and qualify the write of
//             aluout/pcout/memout into rf[dr]; sr/VSR are packed read ports
//             with one clock of latency; psr holds {N,Z,P} of the last
//             committed write; wb_err pulses one cycle after an illegal
//             select; wb_count saturates at all-ones.
//   Build option: define WRITEBACK_RF_BYPASS_EN to forward same-edge write
//   data to a read port addressing the written register; otherwise that
//   port captures the pre-write contents.
module writeback_rf
    import writeback_rf_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned NUM_RD   = 2
) (
    input  logic          clock,
    input  logic          reset,
    writeback_rf_if.slave bus
);

    localparam int unsigned ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]        rf [NUM_REGS];
    logic [NUM_RD*DATA_W-1:0] vsr_q;
    logic [2:0]               psr_q;
    logic                     wb_err_q;
    logic [WB_COUNT_W-1:0]    wb_count_q;

    wb_sel_e           sel;
    logic [DATA_W-1:0] wr_data;
    logic              wr_commit;
    logic              wr_illegal;
    logic [2:0]        wr_psr;

    assign sel = wb_sel_e'(bus.W_Control);

    always_comb begin
        wr_data = '0;
        case (sel)
            WB_SEL_ALU: wr_data = bus.aluout;
            WB_SEL_PC:  wr_data = bus.pcout;
            WB_SEL_MEM: wr_data = bus.memout;
            default:    wr_data = '0;
        endcase
    end

    assign wr_commit  = bus.enable_writeback && (sel != WB_SEL_ILLEGAL);
    assign wr_illegal = bus.enable_writeback && (sel == WB_SEL_ILLEGAL);

    writeback_rf_nzp #(
        .DATA_W (DATA_W)
    ) u_nzp (
        .data (wr_data),
        .psr  (wr_psr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                rf[r] <= '0;
            end
            vsr_q      <= '0;
            psr_q      <= PSR_RESET;
            wb_err_q   <= 1'b0;
            wb_count_q <= '0;
        end else begin
            if (wr_commit) begin
                rf[bus.dr] <= wr_data;
                psr_q      <= wr_psr;
                if (wb_count_q != '1) begin
                    wb_count_q <= wb_count_q + WB_COUNT_W'(1);
                end
            end
            wb_err_q <= wr_illegal;
            for (int unsigned i = 0; i < NUM_RD; i++) begin
`ifdef WRITEBACK_RF_BYPASS_EN
                if (wr_commit && (bus.dr == bus.sr[i*ADDR_W +: ADDR_W])) begin
                    vsr_q[i*DATA_W +: DATA_W] <= wr_data;
                end else begin
                    vsr_q[i*DATA_W +: DATA_W] <= rf[bus.sr[i*ADDR_W +: ADDR_W]];
                end
`else
                vsr_q[i*DATA_W +: DATA_W] <= rf[bus.sr[i*ADDR_W +: ADDR_W]];
`endif
            end
        end
    end

    assign bus.VSR      = vsr_q;
    assign bus.psr      = psr_q;
    assign bus.wb_err   = wb_err_q;
    assign bus.wb_count = wb_count_q;

endmodule

// File: tb/tb_writeback_rf.sv
// tb_writeback_rf
//   Directed self-checking bench for writeback_rf (DATA_W=16, NUM_REGS=8,
//   NUM_RD=2). Expected same-edge read data follows WRITEBACK_RF_BYPASS_EN.
module tb_writeback_rf;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned NUM_RD   = 2;

    logic clock;
    logic reset;

    int tests;
    int failed;

    writeback_rf_if #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) bus ();

    writeback_rf #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_reads(input logic [2:0] r0, input logic [2:0] r1);
        bus.sr = {r1, r0};
    endtask

    task automatic drive_write(input logic [1:0] sel, input logic [2:0] dst,
                               input logic [15:0] data);
        bus.enable_writeback = 1'b1;
        bus.W_Control        = sel;
        bus.dr               = dst;
        bus.aluout           = (sel == 2'd0) ? data : 16'h0;
        bus.pcout            = (sel == 2'd1) ? data : 16'h0;
        bus.memout           = (sel == 2'd2) ? data : 16'h0;
    endtask

    task automatic idle();
        bus.enable_writeback = 1'b0;
        bus.W_Control        = 2'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        set_reads(3'd0, 3'd7);
        tick();
        tick();
        reset = 1'b0;
        tests++;
        if (bus.VSR !== 32'h0) begin
            failed++;
            $display("FAIL reset_vsr: got %h expected %h", bus.VSR, 32'h0);
        end
        tests++;
        if (bus.psr !== 3'b000) begin
            failed++;
            $display("FAIL reset_psr: got %b expected %b", bus.psr, 3'b000);
        end
        tests++;
        if (bus.wb_count !== 16'h0 || bus.wb_err !== 1'b0) begin
            failed++;
            $display("FAIL reset_cnt_err: got cnt=%h err=%b expected cnt=0000 err=0",
                     bus.wb_count, bus.wb_err);
        end
        tick();
        tests++;
        if (bus.VSR !== 32'h0 || bus.psr !== 3'b000 || bus.wb_count !== 16'h0 || bus.wb_err !== 1'b0) begin
            failed++;
            $display("FAIL reset_idle: got vsr=%h psr=%b cnt=%h err=%b expected all zero",
                     bus.VSR, bus.psr, bus.wb_count, bus.wb_err);
        end
    endtask

    task automatic test_write_read();
        drive_write(2'd0, 3'd3, 16'h8001);
        tick();
        idle();
        tests++;
        if (bus.psr !== 3'b100 || bus.wb_count !== 16'd1) begin
            failed++;
            $display("FAIL wr_alu_psr_cnt: got psr=%b cnt=%h expected psr=100 cnt=0001",
                     bus.psr, bus.wb_count);
        end
        set_reads(3'd3, 3'd0);
        tick();
        tests++;
        if (bus.VSR[15:0] !== 16'h8001 || bus.VSR[31:16] !== 16'h0000) begin
            failed++;
            $display("FAIL rd_r3: got vsr0=%h vsr1=%h expected vsr0=8001 vsr1=0000",
                     bus.VSR[15:0], bus.VSR[31:16]);
        end
    endtask

    task automatic test_psr();
        drive_write(2'd2, 3'd5, 16'h0000);
        tick();
        tests++;
        if (bus.psr !== 3'b010) begin
            failed++;
            $display("FAIL psr_zero: got %b expected %b", bus.psr, 3'b010);
        end
        drive_write(2'd1, 3'd5, 16'h0042);
        tick();
        idle();
        tests++;
        if (bus.psr !== 3'b001 || bus.wb_count !== 16'd3) begin
            failed++;
            $display("FAIL psr_pos: got psr=%b cnt=%h expected psr=001 cnt=0003",
                     bus.psr, bus.wb_count);
        end
        set_reads(3'd5, 3'd3);
        tick();
        tests++;
        if (bus.VSR !== {16'h8001, 16'h0042}) begin
            failed++;
            $display("FAIL rd_r5: got %h expected %h", bus.VSR, {16'h8001, 16'h0042});
        end
        tests++;
        if (bus.psr !== 3'b001) begin
            failed++;
            $display("FAIL psr_hold: got %b expected %b", bus.psr, 3'b001);
        end
    endtask

    task automatic test_illegal();
        drive_write(2'd0, 3'd2, 16'h5555);
        tick();
        bus.enable_writeback = 1'b1;
        bus.W_Control        = 2'd3;
        bus.dr               = 3'd2;
        bus.aluout           = 16'h1234;
        bus.pcout            = 16'h8000;
        bus.memout           = 16'h0000;
        tick();
        idle();
        tests++;
        if (bus.wb_err !== 1'b1) begin
            failed++;
            $display("FAIL illegal_err: got %b expected %b", bus.wb_err, 1'b1);
        end
        tests++;
        if (bus.psr !== 3'b001 || bus.wb_count !== 16'd4) begin
            failed++;
            $display("FAIL illegal_state: got psr=%b cnt=%h expected psr=001 cnt=0004",
                     bus.psr, bus.wb_count);
        end
        set_reads(3'd2, 3'd2);
        tick();
        tests++;
        if (bus.wb_err !== 1'b0) begin
            failed++;
            $display("FAIL illegal_pulse: got %b expected %b", bus.wb_err, 1'b0);
        end
        tests++;
        if (bus.VSR !== {16'h5555, 16'h5555}) begin
            failed++;
            $display("FAIL illegal_r2: got %h expected %h", bus.VSR, {16'h5555, 16'h5555});
        end
    endtask

    task automatic test_same_edge();
        logic [15:0] exp_rd;
`ifdef WRITEBACK_RF_BYPASS_EN
        exp_rd = 16'hBEEF;
`else
        exp_rd = 16'h1111;
`endif
        drive_write(2'd0, 3'd1, 16'h1111);
        tick();
        drive_write(2'd0, 3'd1, 16'hBEEF);
        set_reads(3'd1, 3'd1);
        tick();
        idle();
        tests++;
        if (bus.VSR[15:0] !== exp_rd || bus.VSR[31:16] !== exp_rd) begin
            failed++;
            $display("FAIL same_edge: got vsr0=%h vsr1=%h expected both %h",
                     bus.VSR[15:0], bus.VSR[31:16], exp_rd);
        end
        tick();
        tests++;
        if (bus.VSR !== {16'hBEEF, 16'hBEEF}) begin
            failed++;
            $display("FAIL after_same_edge: got %h expected %h", bus.VSR, {16'hBEEF, 16'hBEEF});
        end
    endtask

    task automatic test_reset_dominates();
        drive_write(2'd0, 3'd4, 16'h1111);
        tick();
        reset = 1'b1;
        drive_write(2'd0, 3'd4, 16'h7777);
        tick();
        tests++;
        if (bus.wb_count !== 16'h0 || bus.psr !== 3'b000) begin
            failed++;
            $display("FAIL rst_dom_write: got cnt=%h psr=%b expected cnt=0000 psr=000",
                     bus.wb_count, bus.psr);
        end
        bus.W_Control = 2'd3;
        tick();
        tests++;
        if (bus.wb_err !== 1'b0) begin
            failed++;
            $display("FAIL rst_dom_err: got %b expected %b", bus.wb_err, 1'b0);
        end
        // First cycle out of reset must accept a write.
        reset = 1'b0;
        drive_write(2'd0, 3'd6, 16'h0001);
        tick();
        idle();
        tests++;
        if (bus.psr !== 3'b001 || bus.wb_count !== 16'd1) begin
            failed++;
            $display("FAIL post_rst_write: got psr=%b cnt=%h expected psr=001 cnt=0001",
                     bus.psr, bus.wb_count);
        end
        set_reads(3'd4, 3'd6);
        tick();
        tests++;
        if (bus.VSR !== {16'h0001, 16'h0000}) begin
            failed++;
            $display("FAIL rst_r4_r6: got %h expected %h", bus.VSR, {16'h0001, 16'h0000});
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        drive_write(2'd0, 3'd7, 16'h00A5);
        repeat (65534) tick();
        tests++;
        if (bus.wb_count !== 16'hFFFE) begin
            failed++;
            $display("FAIL cnt_fffe: got %h expected %h", bus.wb_count, 16'hFFFE);
        end
        tick();
        tests++;
        if (bus.wb_count !== 16'hFFFF) begin
            failed++;
            $display("FAIL cnt_ffff: got %h expected %h", bus.wb_count, 16'hFFFF);
        end
        repeat (2) tick();
        idle();
        tests++;
        if (bus.wb_count !== 16'hFFFF) begin
            failed++;
            $display("FAIL cnt_sat: got %h expected %h", bus.wb_count, 16'hFFFF);
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        bus.enable_writeback = 1'b0;
        bus.W_Control        = 2'd0;
        bus.aluout           = 16'h0;
        bus.pcout            = 16'h0;
        bus.memout           = 16'h0;
        bus.dr               = 3'd0;
        bus.sr               = 6'd0;

        test_reset();
        test_write_read();
        test_psr();
        test_illegal();
        test_same_edge();
        test_reset_dominates();
        test_saturation();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
